// File: rtl/cordic_angle_reduce.sv
// cordic_angle_reduce: reduces an IEEE-754 single angle modulo pi/2 into a Q2.30 angle plus quadrant
module cordic_angle_reduce #(
  parameter int QBITS = 7,
  parameter logic [31:0] HALF_PI = 32'h6487ED51
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_angle,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_angle,
  output logic [1:0]  out_quad,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int XW = QBITS + 30;
  localparam int KW = QBITS > 1 ? $clog2(QBITS) : 1;
  typedef enum logic [2:0] {IDLE, CONV, DIV, FIX, OUT} state_t;
  state_t state_q, state_d;
  logic s_q, s_d;
  logic [7:0] e_q, e_d;
  logic [23:0] m_q, m_d;
  logic [XW-1:0] r_q, r_d;
  logic [QBITS-1:0] q_q, q_d;
  logic [KW-1:0] k_q, k_d;
  logic err_q, err_d;
  logic [31:0] angle_q, angle_d;
  logic [1:0] quad_q, quad_d;
  logic oerr_q, oerr_d;
  logic [XW-1:0] mag, conv_x, step;
  logic conv_err, take;
  logic [1:0] q2;
  logic [31:0] r32;
  always_comb begin
    mag = XW'(m_q);
    conv_err = (e_q == 8'd255) || (int'(e_q) >= 127 + QBITS);
    conv_x = (e_q == 8'd0) ? '0 :
             (e_q >= 8'd120) ? mag << (e_q - 8'd120) :
             ((8'd120 - e_q) >= 8'd24) ? '0 : mag >> (8'd120 - e_q);
    step = XW'(HALF_PI) << k_q;
    take = r_q >= step;
    q2 = 2'(q_q);
    r32 = 32'(r_q);
  end
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    e_d = e_q;
    m_d = m_q;
    r_d = r_q;
    q_d = q_q;
    k_d = k_q;
    err_d = err_q;
    angle_d = angle_q;
    quad_d = quad_q;
    oerr_d = oerr_q;
    case (state_q)
      IDLE: begin
        s_d = in_valid ? in_angle[31] : s_q;
        e_d = in_valid ? in_angle[30:23] : e_q;
        m_d = in_valid ? {1'b1, in_angle[22:0]} : m_q;
        state_d = in_valid ? CONV : IDLE;
      end
      CONV: begin
        r_d = conv_err ? '0 : conv_x;
        q_d = '0;
        k_d = KW'(QBITS - 1);
        err_d = conv_err;
        state_d = conv_err ? FIX : DIV;
      end
      DIV: begin
        r_d = take ? r_q - step : r_q;
        q_d = take ? q_q | (QBITS'(1) << k_q) : q_q;
        k_d = k_q - KW'(1);
        state_d = (k_q == '0) ? FIX : DIV;
      end
      FIX: begin
        oerr_d = err_q;
        angle_d = err_q ? '0 : (s_q && r_q != '0) ? HALF_PI - r32 : r32;
        quad_d = err_q ? 2'd0 : !s_q ? q2 : (r_q != '0) ? ~q2 : 2'd0 - q2;
        state_d = OUT;
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q <= 1'b0;
      e_q <= '0;
      m_q <= '0;
      r_q <= '0;
      q_q <= '0;
      k_q <= '0;
      err_q <= 1'b0;
      angle_q <= '0;
      quad_q <= '0;
      oerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      e_q <= e_d;
      m_q <= m_d;
      r_q <= r_d;
      q_q <= q_d;
      k_q <= k_d;
      err_q <= err_d;
      angle_q <= angle_d;
      quad_q <= quad_d;
      oerr_q <= oerr_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign out_angle = angle_q;
  assign out_quad = quad_q;
  assign out_err = oerr_q;
endmodule

// File: tb/tb_cordic_angle_reduce.sv
// tb_cordic_angle_reduce: directed and random checks of cordic_angle_reduce against an arithmetic reference
module tb_cordic_angle_reduce;
  localparam int QBITS = 7;
  localparam logic [31:0] HP = 32'h6487ED51;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] in_angle = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_err, out_valid;
  logic [31:0] out_angle;
  logic [1:0] out_quad;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cordic_angle_reduce #(.QBITS(QBITS), .HALF_PI(HP)) dut (
    .clk(clk), .rst_n(rst_n), .in_angle(in_angle), .in_valid(in_valid), .in_ready(in_ready),
    .out_angle(out_angle), .out_quad(out_quad), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [31:0] a, output logic [31:0] ang, output logic [1:0] qd, output logic er);
    int e;
    longint m, x, q, r;
    e = int'(a[30:23]);
    m = longint'({1'b1, a[22:0]});
    er = (e == 255) || (e >= 127 + QBITS);
    ang = '0;
    qd = '0;
    if (er) return;
    if (e == 0) x = 0;
    else if (e >= 120) x = m * (longint'(2) ** (e - 120));
    else if (120 - e >= 24) x = 0;
    else x = m / (longint'(2) ** (120 - e));
    q = x / longint'(HP);
    r = x % longint'(HP);
    if (!a[31]) begin
      qd = 2'(q % 4);
      ang = 32'(r);
    end else if (r == 0) begin
      qd = 2'((4 - q % 4) % 4);
    end else begin
      qd = 2'(3 - q % 4);
      ang = 32'(longint'(HP) - r);
    end
  endfunction
  task automatic run(input logic [31:0] a, input string tag, output logic [31:0] oa, output logic [1:0] oq, output logic oe);
    logic [31:0] ea;
    logic [1:0] eq;
    logic ee;
    int n;
    model(a, ea, eq, ee);
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready, 1);
    in_angle = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({tag, " in_ready busy"}, in_ready, 0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!out_valid && n < 40);
    chk({tag, " latency"}, n, ee ? 2 : QBITS + 2);
    chk({tag, " angle"}, out_angle, ea);
    chk({tag, " quad"}, out_quad, eq);
    chk({tag, " err"}, out_err, ee);
    oa = out_angle;
    oq = out_quad;
    oe = out_err;
    @(posedge clk);
    #1 chk({tag, " valid one cycle"}, out_valid, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [31:0] dv[10];
    logic [31:0] da[10];
    logic [1:0] dq[10];
    logic de[10];
    logic [31:0] oa;
    logic [1:0] oq;
    logic oe, seen;
    int n;
    dv = '{32'h00000000, 32'h3F800000, 32'h3FC90FDB, 32'h40490FDB, 32'h40C90FDB,
           32'hBFC90FDB, 32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h43000000};
    da = '{32'h0, 32'h40000000, 32'h2F, 32'h5E, 32'hBC, 32'h6487ED22, 32'h0, 32'h0, 32'h0, 32'h0};
    dq = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    de = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_angle", out_angle, 0);
    chk("reset out_quad", out_quad, 0);
    chk("reset out_err", out_err, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(dv[i], $sformatf("dir%0d", i), oa, oq, oe);
      chk($sformatf("dir%0d const angle", i), oa, da[i]);
      chk($sformatf("dir%0d const quad", i), oq, dq[i]);
      chk($sformatf("dir%0d const err", i), oe, de[i]);
    end
    run(32'h42FE0000, "f127", oa, oq, oe);
    chk("f127 const err", oe, 0);
    for (int i = 0; i < 40; i++) begin
      int sel, e;
      sel = $urandom_range(0, 9);
      e = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(100, 136);
      run({1'($urandom), 8'(e), 23'($urandom)}, $sformatf("rnd%0d", i), oa, oq, oe);
    end
    out_ready = 1'b0;
    @(negedge clk);
    in_angle = 32'h40490FDB;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("hold latency", n, QBITS + 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_angle = 32'h3F800000;
      in_valid = (i == 2);
      chk($sformatf("hold%0d valid", i), out_valid, 1);
      chk($sformatf("hold%0d in_ready", i), in_ready, 0);
      chk($sformatf("hold%0d angle", i), out_angle, 32'h5E);
      chk($sformatf("hold%0d quad", i), out_quad, 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("release valid", out_valid, 0);
    chk("release in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    chk("ignored input", seen, 0);
    @(negedge clk);
    in_angle = 32'h40C90FDB;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async rst out_valid", out_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst angle", out_angle, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'h3FC90FDB, "post_rst", oa, oq, oe);
    chk("post_rst const angle", oa, 32'h2F);
    chk("post_rst const quad", oq, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
